// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
// Package    : graphics_pkg
// Purpose    : Definitions shared by the scanout path. Holds the default VRAM
//              and FIFO word and address widths, which must match the
//              asyncfifo instantiation. Also holds the state encoding of the
//              VRAM fetch arbiter.
// Ports      : none
// Revision   : 1.0 - initial release
// ============================================================================
package graphics_pkg;

  localparam int unsigned GFX_DATA_WIDTH = 16;
  localparam int unsigned GFX_ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_DISP_RD  = 3'd1,
    ARB_DISP_WR  = 3'd2,
    ARB_DISP_GAP = 3'd3,
    ARB_CPU_ACC  = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/vram_fetch_counter.sv
`default_nettype none
// ============================================================================
// Module     : vram_fetch_counter
// Purpose    : Display fetch pointer and per-frame remaining-word counter.
//              It also parks a frame_start reload until the arbiter says the
//              pointer may change.
// Ports      : clk, reset (sync, active-low)
//              frame_start, base_addr, frame_words - frame reload request
//              reload_ok       - arbiter allows a reload this cycle
//              step            - one word was written to the FIFO
//              fetch_addr      - current display fetch address
//              words_left      - remaining word count is nonzero
//              restart_pending - a reload is waiting (or arriving now)
// Revision   : 1.0 - initial release
// ============================================================================
module vram_fetch_counter
  import graphics_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = GFX_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] frame_words,
  input  logic                   reload_ok,
  input  logic                   step,
  output logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   words_left,
  output logic                   restart_pending
);

  logic [ADDR_WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  pend_addr_q, pend_addr_d;
  logic [COUNT_WIDTH-1:0] pend_words_q, pend_words_d;

  assign fetch_addr      = fetch_addr_q;
  assign words_left      = (remaining_q != '0);
  assign restart_pending = pend_q | frame_start;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    remaining_d  = remaining_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_words_d = pend_words_q;

    // A newer frame_start always overwrites a parked one.
    if (frame_start) begin
      pend_addr_d  = base_addr;
      pend_words_d = frame_words;
    end

    if (frame_start || pend_q) begin
      if (reload_ok) begin
        // The reload takes precedence over the post-write step.
        fetch_addr_d = frame_start ? base_addr   : pend_addr_q;
        remaining_d  = frame_start ? frame_words : pend_words_q;
        pend_d       = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (step) begin
      fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
      if (remaining_q != '0) begin
        remaining_d = remaining_q - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_words_q <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      remaining_q  <= remaining_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_words_q <= pend_words_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vram_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : vram_fetch_arbiter
// Purpose    : Write-side controller of the scanout FIFO. It shares one VRAM
//              port between display prefetch and CPU accesses. Display has
//              priority, but the CPU waits at most BURST_LIMIT display words.
// Ports      : clk, reset (sync, active-low)
//              frame_start, base_addr, frame_words - frame fetch setup
//              fifo_can_write, fifo_write, fifo_write_data - FIFO write side
//              mem_req, mem_we, mem_addr, mem_wdata, mem_ready, mem_rdata
//                - single VRAM port, one transaction outstanding
//              cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ack, cpu_rdata
//                - CPU access handshake
//              busy - display words still to be fetched this frame
// Revision   : 1.0 - initial release
// ============================================================================
module vram_fetch_arbiter
  import graphics_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = GFX_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = GFX_ADDR_WIDTH,
  parameter int unsigned COUNT_WIDTH = 17,
  parameter int unsigned BURST_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] frame_words,
  input  logic                   fifo_can_write,
  output logic                   fifo_write,
  output logic [DATA_WIDTH-1:0]  fifo_write_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  output logic                   cpu_ack,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic                   busy
);

  localparam int unsigned        BURST_W   = $clog2(BURST_LIMIT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LIMIT);

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  fifo_write_q, fifo_write_d;
  logic [DATA_WIDTH-1:0] fifo_write_data_q, fifo_write_data_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;

  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  words_left;
  logic                  restart_pending;
  logic                  reload_ok;
  logic                  step;
  logic                  disp_want;
  logic                  cpu_req_eff;

  // The pointer may move whenever no display read is waiting on VRAM. An
  // open read or CPU access defers the reload until mem_ready.
  assign reload_ok = (state_q == ARB_IDLE) || (state_q == ARB_DISP_GAP) ||
                     (state_q == ARB_DISP_WR) ||
                     (((state_q == ARB_DISP_RD) || (state_q == ARB_CPU_ACC)) && mem_ready);
  assign step      = (state_q == ARB_DISP_WR);

  vram_fetch_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_counter (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .base_addr      (base_addr),
    .frame_words    (frame_words),
    .reload_ok      (reload_ok),
    .step           (step),
    .fetch_addr     (fetch_addr),
    .words_left     (words_left),
    .restart_pending(restart_pending)
  );

  always_comb begin
    state_d           = state_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    fifo_write_data_d = fifo_write_data_q;
    cpu_ack_d         = 1'b0;
    cpu_rdata_d       = cpu_rdata_q;
    burst_cnt_d       = burst_cnt_q;

    // cpu_req is still high during the ack cycle. It must not restart the
    // same access.
    cpu_req_eff = cpu_req & ~cpu_ack_q;
    disp_want   = words_left & fifo_can_write & ~restart_pending;

    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_req_eff && ((burst_cnt_q == BURST_MAX) || !disp_want)) begin
          state_d     = ARB_CPU_ACC;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else if (disp_want) begin
          state_d    = ARB_DISP_RD;
          mem_we_d   = 1'b0;
          mem_addr_d = fetch_addr;
        end
      end
      ARB_DISP_RD: begin
        if (mem_ready) begin
          // A restart during the read drops the word it returns.
          if (restart_pending) begin
            state_d = ARB_IDLE;
          end else begin
            state_d           = ARB_DISP_WR;
            fifo_write_data_d = mem_rdata;
          end
        end
      end
      ARB_DISP_WR: begin
        state_d = ARB_DISP_GAP;
        if (cpu_req) begin
          if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
          end
        end else begin
          burst_cnt_d = '0;
        end
      end
      ARB_DISP_GAP: begin
        state_d = ARB_IDLE;
      end
      ARB_CPU_ACC: begin
        if (mem_ready) begin
          state_d     = ARB_IDLE;
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = mem_rdata;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // The outputs are registered, so they are decoded from the next state.
    mem_req_d    = (state_d == ARB_DISP_RD) || (state_d == ARB_CPU_ACC);
    fifo_write_d = (state_d == ARB_DISP_WR);
    if (!mem_req_d) begin
      mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= ARB_IDLE;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
      fifo_write_q      <= 1'b0;
      fifo_write_data_q <= '0;
      cpu_ack_q         <= 1'b0;
      cpu_rdata_q       <= '0;
      burst_cnt_q       <= '0;
    end else begin
      state_q           <= state_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      fifo_write_q      <= fifo_write_d;
      fifo_write_data_q <= fifo_write_data_d;
      cpu_ack_q         <= cpu_ack_d;
      cpu_rdata_q       <= cpu_rdata_d;
      burst_cnt_q       <= burst_cnt_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign fifo_write      = fifo_write_q;
  assign fifo_write_data = fifo_write_data_q;
  assign cpu_ack         = cpu_ack_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign busy            = words_left;

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_vram_fetch_arbiter
// Purpose    : Self-checking bench for vram_fetch_arbiter. It contains a VRAM
//              model with programmable latency. Scoreboards hold the expected
//              FIFO data and CPU read data. A CPU vector table drives the CPU
//              accesses.
// Ports      : none
// Revision   : 1.0 - initial release
// ============================================================================
module tb_vram_fetch_arbiter;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic [15:0] base_addr;
  logic [16:0] frame_words;
  logic        fifo_can_write;
  logic        fifo_write;
  logic [15:0] fifo_write_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        busy;

  vram_fetch_arbiter #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (16),
    .COUNT_WIDTH(17),
    .BURST_LIMIT(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .base_addr      (base_addr),
    .frame_words    (frame_words),
    .fifo_can_write (fifo_can_write),
    .fifo_write     (fifo_write),
    .fifo_write_data(fifo_write_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_ack        (cpu_ack),
    .cpu_rdata      (cpu_rdata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  int          lat         = 1;
  int          mem_cnt     = 0;
  int          writes      = 0;
  int          req_cycles  = 0;
  logic        req_prev    = 1'b0;
  logic [15:0] mem [0:65535];
  logic [15:0] exp_q  [$];
  int          cpu_q  [$];
  logic [15:0] rd_log [$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_rd;   // -1: no read-data check
  } cpu_vec_t;

  cpu_vec_t vecs [5];

  // Initial VRAM contents. Multiplying by 3 and adding a constant is a
  // bijection mod 2^16, so each data word identifies its source address.
  function automatic logic [15:0] vram_init(input logic [15:0] a);
    return a * 16'd3 + 16'h1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // VRAM model. mem_ready is raised in the lat-th cycle of a request.
  always @(negedge clk) begin
    if (!reset) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mem_cnt   = 0;
    end else if (mem_req) begin
      mem_cnt++;
      if (mem_cnt >= lat) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata = mem[mem_addr];
        mem_ready = 1'b1;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Output monitor and scoreboards.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_req) req_cycles++;
      if (mem_req && !req_prev && !mem_we) rd_log.push_back(mem_addr);
      req_prev = mem_req;
      if (fifo_write) begin
        writes++;
        if (exp_q.size() == 0) check("fifo_write_queue", exp_q.size(), 1);
        else check("fifo_write_data", fifo_write_data, exp_q.pop_front());
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) check("cpu_ack_queue", cpu_q.size(), 1);
        else begin
          int e;
          e = cpu_q.pop_front();
          if (e >= 0) check("cpu_rdata", cpu_rdata, e);
        end
      end
    end else begin
      req_prev = 1'b0;
    end
  end

  task automatic start_frame(input logic [15:0] base, input int words);
    logic [15:0] a;
    exp_q.delete();
    for (int i = 0; i < words; i++) begin
      a = base + 16'(i);
      exp_q.push_back(vram_init(a));
    end
    writes      = 0;
    frame_start = 1'b1;
    base_addr   = base;
    frame_words = 17'(words);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int b;
    b = budget;
    while (busy && b > 0) begin
      tick();
      b--;
    end
    check(name, busy, 0);
  endtask

  task automatic wait_writes(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (writes < n && b > 0) begin
      tick();
      b--;
    end
    check(name, writes, n);
  endtask

  task automatic wait_req(input string name, input int budget);
    int b;
    b = budget;
    while (!mem_req && b > 0) begin
      tick();
      b--;
    end
    check(name, mem_req, 1);
  endtask

  task automatic wait_ack(input string name, input int budget);
    int b;
    b = budget;
    while (!cpu_ack && b > 0) begin
      tick();
      b--;
    end
    check(name, cpu_ack, 1);
  endtask

  initial begin
    int writes_at_ack;
    int b;

    for (int i = 0; i < 65536; i++) mem[i] = vram_init(16'(i));
    reset = 1'b0; frame_start = 1'b0; base_addr = '0; frame_words = '0;
    fifo_can_write = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    vecs[0] = '{1'b1, 16'h0020, 16'hBEEF, -1};
    vecs[1] = '{1'b0, 16'h0020, 16'h0000, 32'h0000BEEF};
    vecs[2] = '{1'b1, 16'h0021, 16'h1234, -1};
    vecs[3] = '{1'b0, 16'h0021, 16'h0000, 32'h00001234};
    vecs[4] = '{1'b0, 16'h0030, 16'h0000, int'(vram_init(16'h0030))};

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {mem_req, mem_we, fifo_write, cpu_ack, busy}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_fifo_data", fifo_write_data, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    reset = 1'b1;
    tick();

    // Display fill
    start_frame(16'h1000, 4);
    check("fill_busy_set", busy, 1);
    wait_busy_low("fill_busy_low", 100);
    check("fill_writes_at_busy_low", writes, 4);
    req_cycles = 0;
    repeat (10) tick();
    check("fill_no_more_req", req_cycles, 0);
    check("fill_queue_empty", exp_q.size(), 0);

    // FIFO full stall
    start_frame(16'h3000, 6);
    wait_writes("stall_two_writes", 2, 100);
    fifo_can_write = 1'b0;
    req_cycles = 0;
    rd_log.delete();
    repeat (20) tick();
    check("stall_no_req", req_cycles, 0);
    fifo_can_write = 1'b1;
    wait_busy_low("stall_busy_low", 200);
    repeat (2) tick();
    check("stall_total_writes", writes, 6);
    check("stall_resume_addr", rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hDEAD, 32'h3002);

    // Starvation bound
    start_frame(16'h4000, 100);
    wait_req("starve_first_req", 20);
    cpu_q.push_back(int'(vram_init(16'h0100)));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    wait_ack("starve_ack_seen", 500);
    writes_at_ack = writes;
    cpu_req = 1'b0;
    check("starve_writes_before_ack", writes_at_ack, 8);
    wait_busy_low("starve_busy_low", 2000);
    repeat (2) tick();
    check("starve_total_writes", writes, 100);
    check("starve_queue_empty", exp_q.size(), 0);

    // CPU-only accesses from a vector table. cpu_req is held one cycle past
    // the ack to show the ack cycle does not re-service it.
    for (int v = 0; v < 5; v++) begin
      cpu_q.push_back(vecs[v].exp_rd);
      cpu_req   = 1'b1;
      cpu_we    = vecs[v].we;
      cpu_addr  = vecs[v].addr;
      cpu_wdata = vecs[v].wdata;
      wait_req("cpu_req_seen", 20);
      check("cpu_mem_we", mem_we, vecs[v].we);
      check("cpu_mem_addr", mem_addr, vecs[v].addr);
      wait_ack("cpu_ack_seen", 20);
      tick();
      cpu_req = 1'b0;
      repeat (3) tick();
    end
    check("cpu_queue_empty", cpu_q.size(), 0);

    // Restart mid-read
    start_frame(16'h1000, 10);
    wait_writes("restart_five_writes", 5, 200);
    lat = 5;
    b = 50;
    while (!(mem_req && mem_addr == 16'h1005) && b > 0) begin
      tick();
      b--;
    end
    check("restart_read_1005", mem_addr, 16'h1005);
    tick();
    rd_log.delete();
    start_frame(16'h2000, 3);
    wait_busy_low("restart_busy_low", 300);
    repeat (2) tick();
    check("restart_writes", writes, 3);
    check("restart_next_addr", rd_log.size() > 0 ? 32'(rd_log[0]) : 32'hDEAD, 32'h2000);
    check("restart_queue_empty", exp_q.size(), 0);

    // Reset in DISP_RD
    start_frame(16'h5000, 4);
    wait_req("rstmid_req", 20);
    reset = 1'b0;
    tick();
    check("rstmid_ctrl", {mem_req, mem_we, fifo_write, cpu_ack, busy}, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    lat = 1;
    tick();

    // Address wrap
    rd_log.delete();
    start_frame(16'hFFFE, 3);
    wait_busy_low("wrap_busy_low", 100);
    repeat (2) tick();
    check("wrap_writes", writes, 3);
    check("wrap_nreads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("wrap_addr0", rd_log[0], 16'hFFFE);
      check("wrap_addr1", rd_log[1], 16'hFFFF);
      check("wrap_addr2", rd_log[2], 16'h0000);
    end

    // Empty frame
    start_frame(16'h6000, 0);
    req_cycles = 0;
    repeat (10) tick();
    check("empty_busy", busy, 0);
    check("empty_no_req", req_cycles, 0);
    check("empty_no_writes", writes, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_fetch_arbiter.md
Name: vram_fetch_arbiter

Overview:
- Single-clock controller on the write side of the scanout asyncfifo.
- Shares one VRAM read/write port between two requesters:
  - display prefetch, which reads VRAM words into the FIFO;
  - CPU accesses.
- Display has priority, with a bounded-starvation guarantee for the CPU.
- Reloads the fetch pointer at each frame start.

Parameters:
- DATA_WIDTH, 16, VRAM and FIFO word width.
- ADDR_WIDTH, 16, VRAM word-address width.
- COUNT_WIDTH, 17, width of the per-frame word counter.
- BURST_LIMIT, 8, maximum consecutive display fetches while cpu_req is pending (minimum 1).

Ports:
- clk  in  1  system clock; also the FIFO write_clk.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- frame_start  in  1  one-cycle pulse: begin a new frame's fetch.
- base_addr  in  ADDR_WIDTH  first VRAM address of the frame; sampled on frame_start.
- frame_words  in  COUNT_WIDTH  words to fetch per frame; sampled on frame_start.
- fifo_can_write  in  1  FIFO has at least one free slot.
- fifo_write  out  1  FIFO write strobe.
- fifo_write_data  out  DATA_WIDTH  FIFO write data.
- mem_req  out  1  VRAM request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  VRAM address.
- mem_wdata  out  DATA_WIDTH  VRAM write data.
- mem_ready  in  1  request completes this cycle; mem_rdata valid for reads.
- mem_rdata  in  DATA_WIDTH  VRAM read data.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ack is high.
- busy  out  1  remaining word count is nonzero.

Behaviour:
- Reset (reset=0 at a clk edge):
  - all outputs 0; state IDLE;
  - fetch_addr=0, remaining=0, burst_cnt=0;
  - applies even mid-transaction; any VRAM cycle in flight is abandoned.
- States: IDLE, DISP_RD, DISP_WR, DISP_GAP, CPU_ACC.
- IDLE arbitration, evaluated each cycle in this order:
  - disp_want = remaining!=0 and fifo_can_write and no pending restart.
  - cpu_req and (burst_cnt==BURST_LIMIT or !disp_want) -> CPU_ACC.
  - else disp_want -> DISP_RD.
  - else stay in IDLE.
- DISP_RD:
  - mem_req=1, mem_we=0, mem_addr=fetch_addr; held stable until mem_ready.
  - On mem_ready: latch mem_rdata into fifo_write_data; go to DISP_WR.
- DISP_WR:
  - fifo_write=1 for exactly one cycle.
  - fetch_addr+=1, wrapping modulo 2^ADDR_WIDTH.
  - remaining-=1.
  - burst_cnt+=1 if cpu_req, else burst_cnt=0.
  - Go to DISP_GAP.
- DISP_GAP:
  - One idle cycle, so the FIFO's can_write reflects the write before the next issue; then IDLE.
  - Peak display throughput: one word per (latency+3) cycles.
- CPU_ACC:
  - mem_req=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ready: cpu_ack=1 next cycle, cpu_rdata=mem_rdata latched; burst_cnt=0; go to IDLE.
  - cpu_req must be ignored in the cycle cpu_ack is high; no double service.
- Only one VRAM transaction is ever outstanding.
- mem_req deasserts in the cycle after mem_ready.
- The FIFO is never written unless fifo_can_write was 1 when the read was issued; only this block writes the FIFO, so the slot stays free.
- frame_start:
  - From IDLE or DISP_GAP: load fetch_addr=base_addr and remaining=frame_words at once.
  - From DISP_RD: the read completes, the data is discarded (no fifo_write), and the reload applies at completion.
  - From CPU_ACC: the CPU access completes normally; the reload is held pending until it finishes.
  - A frame_start during DISP_WR reloads after the write; the write still occurs.
  - A second frame_start while one is pending: use the latest base_addr/frame_words.
- frame_words=0: no fetches; busy stays 0.
- remaining saturates at 0 and never underflows.

Decomposition:
- Shared package graphics_pkg:
  - state encoding enum for the arbiter;
  - DATA_WIDTH/ADDR_WIDTH defaults shared with asyncfifo instantiation.
- Natural sub-module: vram_fetch_counter.
  - Holds fetch_addr, remaining, and the pending frame_start reload.
  - Outputs the current address and a nonzero flag.
- The arbiter FSM and burst counter stay in the top module.

Test Plan:
- Display fill:
  - Stimulus: frame_start with base_addr=0x1000, frame_words=4; fifo_can_write=1; mem_ready 1 cycle after each mem_req; no CPU.
  - Required: exactly 4 fifo_write pulses carrying the data at 0x1000..0x1003 in order; busy falls after the 4th; no further mem_req.
- FIFO full stall:
  - Stimulus: drop fifo_can_write after the 2nd write; raise it 20 cycles later.
  - Required: no mem_req while it is low; fetch resumes at base+2; total writes=frame_words.
- Starvation bound:
  - Stimulus: BURST_LIMIT=8; cpu_req held during a 100-word frame.
  - Required: cpu_ack occurs after exactly 8 display writes; the CPU read returns the correct word.
- CPU-only write then read:
  - Stimulus: remaining=0; write 0xBEEF at 0x0020, then read 0x0020.
  - Required: mem_we=1 then 0; cpu_rdata=0xBEEF on the second cpu_ack.
- Restart mid-read:
  - Stimulus: frame_start with base=0x2000 while a read of 0x1005 waits on mem_ready (delay 5).
  - Required: no fifo_write for 0x1005; the next mem_addr is 0x2000; remaining=new frame_words.
- Reset mid-operation and wrap:
  - Stimulus: reset=0 in DISP_RD.
  - Required: outputs 0 next cycle.
  - Stimulus: then base=0xFFFE, frame_words=3.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000.
